// File: rtl/wb_scoreboard_if.sv
// Scoreboard bus: issue, writeback, store completion, flush and hazard query.
// master drives the pipeline events and the query; slave answers ready, hazard and error.
interface wb_scoreboard_if #(
   parameter int THREADS = 4,
   parameter int REGS    = 32
);
   localparam int TW = $clog2(THREADS);
   localparam int RW = $clog2(REGS);

   logic          iss_valid;
   logic [TW-1:0] iss_thread;
   logic          iss_wr;
   logic [RW-1:0] iss_dst;
   logic          iss_store;
   logic          iss_ready;

   logic          wb_valid;
   logic [TW-1:0] wb_thread;
   logic [RW-1:0] wb_dst;

   logic          st_done;

   logic          flush_valid;
   logic [TW-1:0] flush_thread;

   logic [TW-1:0] q_thread;
   logic [RW-1:0] q_src1;
   logic [RW-1:0] q_src2;
   logic          q_mem;
   logic          q_hazard;

   logic          err_underflow;

   modport master (
      output iss_valid, iss_thread, iss_wr, iss_dst, iss_store,
      output wb_valid, wb_thread, wb_dst,
      output st_done,
      output flush_valid, flush_thread,
      output q_thread, q_src1, q_src2, q_mem,
      input  iss_ready, q_hazard, err_underflow
   );

   modport slave (
      input  iss_valid, iss_thread, iss_wr, iss_dst, iss_store,
      input  wb_valid, wb_thread, wb_dst,
      input  st_done,
      input  flush_valid, flush_thread,
      input  q_thread, q_src1, q_src2, q_mem,
      output iss_ready, q_hazard, err_underflow
   );
endinterface

// File: rtl/wb_scoreboard.sv
// Per-thread pending-write scoreboard: issue increments, writeback decrements, decode queries.
// State updates land one cycle after the event; iss_ready drops only when the targeted counter is saturated.
module wb_scoreboard #(
   parameter int THREADS = 4,
   parameter int REGS    = 32,
   parameter int CNTW    = 2,
   parameter int STW     = 3
) (
   input logic           clk,
   input logic           rst,
   wb_scoreboard_if.slave bus
);
   localparam int TW = $clog2(THREADS);
   localparam int RW = $clog2(REGS);
   localparam logic [CNTW-1:0] CNT_MAX = '1;
   localparam logic [STW-1:0]  ST_MAX  = '1;

   logic [CNTW-1:0] cnt [THREADS][REGS];
   logic [STW-1:0]  st_cnt;
   logic            err_q;

   logic iss_acc;
   logic iss_wr_acc;
   logic iss_st_acc;
   logic wr_sat;
   logic st_sat;
   logic wb_flushed;
   logic wb_paired;
   logic wb_uf;
   logic st_uf;

   assign wr_sat = (cnt[bus.iss_thread][bus.iss_dst] == CNT_MAX);
   assign st_sat = (st_cnt == ST_MAX);

   assign bus.iss_ready = !((bus.iss_wr && wr_sat) || (bus.iss_store && st_sat));

   assign iss_acc    = bus.iss_valid && bus.iss_ready;
   assign iss_wr_acc = iss_acc && bus.iss_wr;
   assign iss_st_acc = iss_acc && bus.iss_store;

   // A retire cancelled by flush or netted against a same-counter issue is not an underflow.
   assign wb_flushed = bus.flush_valid && (bus.flush_thread == bus.wb_thread);
   assign wb_paired  = iss_wr_acc && (bus.iss_thread == bus.wb_thread)
                       && (bus.iss_dst == bus.wb_dst);
   assign wb_uf      = bus.wb_valid && !wb_flushed && !wb_paired
                       && (cnt[bus.wb_thread][bus.wb_dst] == '0);
   assign st_uf      = bus.st_done && !iss_st_acc && (st_cnt == '0);

   for (genvar t = 0; t < THREADS; t++) begin : g_thread
      logic flush_hit;
      assign flush_hit = bus.flush_valid && (bus.flush_thread == TW'(t));

      for (genvar r = 0; r < REGS; r++) begin : g_reg
         logic [CNTW-1:0] cnt_q;
         logic            inc;
         logic            dec;

         assign inc = iss_wr_acc && (bus.iss_thread == TW'(t)) && (bus.iss_dst == RW'(r));
         assign dec = bus.wb_valid && (bus.wb_thread == TW'(t)) && (bus.wb_dst == RW'(r));

         // Saturation is prevented upstream by iss_ready, so inc never wraps.
         always_ff @(posedge clk) begin
            if (rst) begin
               cnt_q <= '0;
            end else if (flush_hit) begin
               cnt_q <= '0;
            end else if (inc && !dec) begin
               cnt_q <= cnt_q + CNTW'(1);
            end else if (dec && !inc && (cnt_q != '0)) begin
               cnt_q <= cnt_q - CNTW'(1);
            end
         end

         assign cnt[t][r] = cnt_q;
      end
   end

   // Stores already issued still complete in memory, so flush leaves st_cnt alone.
   always_ff @(posedge clk) begin
      if (rst) begin
         st_cnt <= '0;
      end else if (iss_st_acc && !bus.st_done) begin
         st_cnt <= st_cnt + STW'(1);
      end else if (bus.st_done && !iss_st_acc && (st_cnt != '0)) begin
         st_cnt <= st_cnt - STW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         err_q <= 1'b0;
      end else if (wb_uf || st_uf) begin
         err_q <= 1'b1;
      end
   end

   assign bus.err_underflow = err_q;

   assign bus.q_hazard = (cnt[bus.q_thread][bus.q_src1] != '0)
                      || (cnt[bus.q_thread][bus.q_src2] != '0)
                      || (bus.q_mem && (st_cnt != '0));
endmodule

// File: tb/tb_wb_scoreboard.sv
// Scenario bench for wb_scoreboard: expectations queued with stimulus, popped at sample time.
module tb_wb_scoreboard;
   logic clk;
   logic rst;

   wb_scoreboard_if #(.THREADS(4), .REGS(32)) bus ();

   wb_scoreboard #(.THREADS(4), .REGS(32), .CNTW(2), .STW(3)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   typedef struct {
      string name;
      logic  val;
   } exp_t;

   exp_t exp_q[$];
   exp_t e;
   int   checks = 0;
   int   errors = 0;

   initial begin
      clk = 1'b0;
      forever #10 clk = ~clk;
   end

   task automatic idle();
      bus.iss_valid    = 1'b0;
      bus.iss_thread   = '0;
      bus.iss_wr       = 1'b0;
      bus.iss_dst      = '0;
      bus.iss_store    = 1'b0;
      bus.wb_valid     = 1'b0;
      bus.wb_thread    = '0;
      bus.wb_dst       = '0;
      bus.st_done      = 1'b0;
      bus.flush_valid  = 1'b0;
      bus.flush_thread = '0;
      bus.q_thread     = '0;
      bus.q_src1       = '0;
      bus.q_src2       = '0;
      bus.q_mem        = 1'b0;
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drive_iss(input logic [1:0] th, input logic wr, input logic [4:0] dst, input logic st);
      bus.iss_valid  = 1'b1;
      bus.iss_thread = th;
      bus.iss_wr     = wr;
      bus.iss_dst    = dst;
      bus.iss_store  = st;
   endtask

   task automatic drive_wb(input logic [1:0] th, input logic [4:0] dst);
      bus.wb_valid  = 1'b1;
      bus.wb_thread = th;
      bus.wb_dst    = dst;
   endtask

   task automatic set_q(input logic [1:0] th, input logic [4:0] s1, input logic [4:0] s2, input logic mem);
      bus.q_thread = th;
      bus.q_src1   = s1;
      bus.q_src2   = s2;
      bus.q_mem    = mem;
   endtask

   task automatic test_reset();
      idle();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      bus.iss_wr = 1'b1;
      bus.iss_store = 1'b1;
      set_q(0, 0, 0, 1'b1);
      exp_q.push_back('{"reset_ready", 1'b1});
      exp_q.push_back('{"reset_hazard", 1'b0});
      exp_q.push_back('{"reset_err", 1'b0});
      #1;
      e = exp_q.pop_front(); checks++;
      if (bus.iss_ready !== e.val) begin errors++; $display("FAIL %s: got %b expected %b", e.name, bus.iss_ready, e.val); end
      e = exp_q.pop_front(); checks++;
      if (bus.q_hazard !== e.val) begin errors++; $display("FAIL %s: got %b expected %b", e.name, bus.q_hazard, e.val); end
      e = exp_q.pop_front(); checks++;
      if (bus.err_underflow !== e.val) begin errors++; $display("FAIL %s: got %b expected %b", e.name, bus.err_underflow, e.val); end
      idle();
   endtask

   task automatic test_raw();
      drive_iss(0, 1'b1, 5, 1'b0);
      set_q(0, 5, 0, 1'b0);
      exp_q.push_back('{"raw_no_iss_bypass", 1'b0});
      #1; e = exp_q.pop_front(); checks++;
      if (bus.q_hazard !== e.val) begin errors++; $display("FAIL %s: got %b expected %b", e.name, bus.q_hazard, e.val); end
      step(); idle();
      set_q(0, 5, 0, 1'b0);
      exp_q.push_back('{"raw_t0_hit", 1'b1});
      #1; e = exp_q.pop_front(); checks++;
      if (bus.q_hazard !== e.val) begin errors++; $display("FAIL %s: got %b expected %b", e.name, bus.q_hazard, e.val); end
      set_q(1, 5, 5, 1'b0);
      exp_q.push_back('{"raw_t1_isolated", 1'b0});
      #1; e = exp_q.pop_front(); checks++;
      if (bus.q_hazard !== e.val) begin errors++; $display("FAIL %s: got %b expected %b", e.name, bus.q_hazard, e.val); end
      set_q(0, 0, 5, 1'b0);
      drive_wb(0, 5);
      exp_q.push_back('{"raw_no_wb_bypass", 1'b1});
      #1; e = exp_q.pop_front(); checks++;
      if (bus.q_hazard !== e.val) begin errors++; $display("FAIL %s: got %b expected %b", e.name, bus.q_hazard, e.val); end
      step(); idle();
      set_q(0, 5, 0, 1'b0);
      exp_q.push_back('{"raw_cleared", 1'b0});
      #1; e = exp_q.pop_front(); checks++;
      if (bus.q_hazard !== e.val) begin errors++; $display("FAIL %s: got %b expected %b", e.name, bus.q_hazard, e.val); end
   endtask

   task automatic test_saturation();
      for (int i = 0; i < 3; i++) begin
         drive_iss(2, 1'b1, 7, 1'b0);
         exp_q.push_back('{"sat_fill_ready", 1'b1});
         #1; e = exp_q.pop_front(); checks++;
         if (bus.iss_ready !== e.val) begin errors++; $display("FAIL %s[%0d]: got %b expected %b", e.name, i, bus.iss_ready, e.val); end
         step();
      end
      idle();
      bus.iss_thread = 2; bus.iss_wr = 1'b1; bus.iss_dst = 7;
      exp_q.push_back('{"sat_full", 1'b0});
      #1; e = exp_q.pop_front(); checks++;
      if (bus.iss_ready !== e.val) begin errors++; $display("FAIL %s: got %b expected %b", e.name, bus.iss_ready, e.val); end
      bus.iss_dst = 8;
      exp_q.push_back('{"sat_other_reg", 1'b1});
      #1; e = exp_q.pop_front(); checks++;
      if (bus.iss_ready !== e.val) begin errors++; $display("FAIL %s: got %b expected %b", e.name, bus.iss_ready, e.val); end
      // Issue attempt against the saturated counter must be dropped.
      drive_iss(2, 1'b1, 7, 1'b0);
      step(); idle();
      drive_wb(2, 7);
      step(); idle();
      bus.iss_thread = 2; bus.iss_wr = 1'b1; bus.iss_dst = 7;
      exp_q.push_back('{"sat_ready_back", 1'b1});
      #1; e = exp_q.pop_front(); checks++;
      if (bus.iss_ready !== e.val) begin errors++; $display("FAIL %s: got %b expected %b", e.name, bus.iss_ready, e.val); end
      set_q(2, 7, 7, 1'b0);
      exp_q.push_back('{"sat_two_left", 1'b1});
      #1; e = exp_q.pop_front(); checks++;
      if (bus.q_hazard !== e.val) begin errors++; $display("FAIL %s: got %b expected %b", e.name, bus.q_hazard, e.val); end
      idle();
      for (int i = 0; i < 2; i++) begin
         drive_wb(2, 7);
         step();
      end
      idle();
      set_q(2, 7, 7, 1'b0);
      exp_q.push_back('{"sat_drained", 1'b0});
      exp_q.push_back('{"sat_no_underflow", 1'b0});
      #1; e = exp_q.pop_front(); checks++;
      if (bus.q_hazard !== e.val) begin errors++; $display("FAIL %s: got %b expected %b", e.name, bus.q_hazard, e.val); end
      e = exp_q.pop_front(); checks++;
      if (bus.err_underflow !== e.val) begin errors++; $display("FAIL %s: got %b expected %b", e.name, bus.err_underflow, e.val); end
   endtask

   task automatic test_same_cycle();
      idle();
      drive_iss(1, 1'b1, 3, 1'b0);
      step(); idle();
      drive_iss(1, 1'b1, 3, 1'b0);
      drive_wb(1, 3);
      step(); idle();
      set_q(1, 3, 0, 1'b0);
      exp_q.push_back('{"pair_at_one_hazard", 1'b1});
      exp_q.push_back('{"pair_at_one_err", 1'b0});
      #1; e = exp_q.pop_front(); checks++;
      if (bus.q_hazard !== e.val) begin errors++; $display("FAIL %s: got %b expected %b", e.name, bus.q_hazard, e.val); end
      e = exp_q.pop_front(); checks++;
      if (bus.err_underflow !== e.val) begin errors++; $display("FAIL %s: got %b expected %b", e.name, bus.err_underflow, e.val); end
      idle();
      drive_wb(1, 3);
      step(); idle();
      set_q(1, 3, 3, 1'b0);
      exp_q.push_back('{"pair_drain", 1'b0});
      #1; e = exp_q.pop_front(); checks++;
      if (bus.q_hazard !== e.val) begin errors++; $display("FAIL %s: got %b expected %b", e.name, bus.q_hazard, e.val); end
      idle();
      drive_iss(1, 1'b1, 3, 1'b0);
      drive_wb(1, 3);
      step(); idle();
      set_q(1, 3, 3, 1'b0);
      exp_q.push_back('{"pair_at_zero_hazard", 1'b0});
      exp_q.push_back('{"pair_at_zero_err", 1'b0});
      #1; e = exp_q.pop_front(); checks++;
      if (bus.q_hazard !== e.val) begin errors++; $display("FAIL %s: got %b expected %b", e.name, bus.q_hazard, e.val); end
      e = exp_q.pop_front(); checks++;
      if (bus.err_underflow !== e.val) begin errors++; $display("FAIL %s: got %b expected %b", e.name, bus.err_underflow, e.val); end
      idle();
   endtask

   task automatic test_store();
      drive_iss(0, 1'b0, 0, 1'b1);
      step(); idle();
      set_q(3, 0, 0, 1'b1);
      exp_q.push_back('{"st_mem_hazard", 1'b1});
      #1; e = exp_q.pop_front(); checks++;
      if (bus.q_hazard !== e.val) begin errors++; $display("FAIL %s: got %b expected %b", e.name, bus.q_hazard, e.val); end
      bus.q_mem = 1'b0;
      exp_q.push_back('{"st_nonmem_clean", 1'b0});
      #1; e = exp_q.pop_front(); checks++;
      if (bus.q_hazard !== e.val) begin errors++; $display("FAIL %s: got %b expected %b", e.name, bus.q_hazard, e.val); end
      bus.st_done = 1'b1;
      step(); idle();
      set_q(3, 0, 0, 1'b1);
      exp_q.push_back('{"st_cleared", 1'b0});
      exp_q.push_back('{"st_no_err", 1'b0});
      #1; e = exp_q.pop_front(); checks++;
      if (bus.q_hazard !== e.val) begin errors++; $display("FAIL %s: got %b expected %b", e.name, bus.q_hazard, e.val); end
      e = exp_q.pop_front(); checks++;
      if (bus.err_underflow !== e.val) begin errors++; $display("FAIL %s: got %b expected %b", e.name, bus.err_underflow, e.val); end
      bus.st_done = 1'b1;
      step(); idle();
      set_q(3, 0, 0, 1'b1);
      exp_q.push_back('{"st_underflow", 1'b1});
      exp_q.push_back('{"st_hold_zero", 1'b0});
      #1; e = exp_q.pop_front(); checks++;
      if (bus.err_underflow !== e.val) begin errors++; $display("FAIL %s: got %b expected %b", e.name, bus.err_underflow, e.val); end
      e = exp_q.pop_front(); checks++;
      if (bus.q_hazard !== e.val) begin errors++; $display("FAIL %s: got %b expected %b", e.name, bus.q_hazard, e.val); end
      step(); step();
      exp_q.push_back('{"st_sticky", 1'b1});
      #1; e = exp_q.pop_front(); checks++;
      if (bus.err_underflow !== e.val) begin errors++; $display("FAIL %s: got %b expected %b", e.name, bus.err_underflow, e.val); end
      idle();
   endtask

   task automatic test_flush();
      drive_iss(0, 1'b1, 1, 1'b0); step();
      drive_iss(0, 1'b1, 2, 1'b0); step();
      drive_iss(3, 1'b1, 1, 1'b0); step();
      idle();
      set_q(0, 1, 2, 1'b0);
      exp_q.push_back('{"fl_pre_t0", 1'b1});
      #1; e = exp_q.pop_front(); checks++;
      if (bus.q_hazard !== e.val) begin errors++; $display("FAIL %s: got %b expected %b", e.name, bus.q_hazard, e.val); end
      bus.flush_valid = 1'b1;
      bus.flush_thread = 0;
      drive_iss(0, 1'b1, 4, 1'b0);
      step(); idle();
      set_q(0, 1, 1, 1'b0);
      exp_q.push_back('{"fl_t0_r1", 1'b0});
      #1; e = exp_q.pop_front(); checks++;
      if (bus.q_hazard !== e.val) begin errors++; $display("FAIL %s: got %b expected %b", e.name, bus.q_hazard, e.val); end
      set_q(0, 2, 2, 1'b0);
      exp_q.push_back('{"fl_t0_r2", 1'b0});
      #1; e = exp_q.pop_front(); checks++;
      if (bus.q_hazard !== e.val) begin errors++; $display("FAIL %s: got %b expected %b", e.name, bus.q_hazard, e.val); end
      set_q(0, 4, 4, 1'b0);
      exp_q.push_back('{"fl_t0_r4", 1'b0});
      #1; e = exp_q.pop_front(); checks++;
      if (bus.q_hazard !== e.val) begin errors++; $display("FAIL %s: got %b expected %b", e.name, bus.q_hazard, e.val); end
      set_q(3, 1, 1, 1'b0);
      exp_q.push_back('{"fl_t3_kept", 1'b1});
      #1; e = exp_q.pop_front(); checks++;
      if (bus.q_hazard !== e.val) begin errors++; $display("FAIL %s: got %b expected %b", e.name, bus.q_hazard, e.val); end
      drive_wb(3, 1);
      step(); idle();
   endtask

   task automatic test_store_full_reset();
      drive_iss(1, 1'b1, 9, 1'b0);
      step();
      for (int i = 0; i < 7; i++) begin
         drive_iss(0, 1'b0, 0, 1'b1);
         step();
      end
      idle();
      bus.iss_store = 1'b1;
      exp_q.push_back('{"stfull_block", 1'b0});
      #1; e = exp_q.pop_front(); checks++;
      if (bus.iss_ready !== e.val) begin errors++; $display("FAIL %s: got %b expected %b", e.name, bus.iss_ready, e.val); end
      bus.iss_store = 1'b0; bus.iss_wr = 1'b1; bus.iss_dst = 10;
      exp_q.push_back('{"stfull_nonstore", 1'b1});
      #1; e = exp_q.pop_front(); checks++;
      if (bus.iss_ready !== e.val) begin errors++; $display("FAIL %s: got %b expected %b", e.name, bus.iss_ready, e.val); end
      set_q(1, 9, 9, 1'b0);
      exp_q.push_back('{"pre_rst_hazard", 1'b1});
      #1; e = exp_q.pop_front(); checks++;
      if (bus.q_hazard !== e.val) begin errors++; $display("FAIL %s: got %b expected %b", e.name, bus.q_hazard, e.val); end
      idle();
      rst = 1'b1;
      drive_iss(1, 1'b1, 9, 1'b0);
      bus.st_done = 1'b1;
      step();
      rst = 1'b0;
      idle();
      bus.iss_store = 1'b1;
      set_q(1, 9, 9, 1'b1);
      exp_q.push_back('{"rst_ready", 1'b1});
      exp_q.push_back('{"rst_hazard", 1'b0});
      exp_q.push_back('{"rst_err", 1'b0});
      #1;
      e = exp_q.pop_front(); checks++;
      if (bus.iss_ready !== e.val) begin errors++; $display("FAIL %s: got %b expected %b", e.name, bus.iss_ready, e.val); end
      e = exp_q.pop_front(); checks++;
      if (bus.q_hazard !== e.val) begin errors++; $display("FAIL %s: got %b expected %b", e.name, bus.q_hazard, e.val); end
      e = exp_q.pop_front(); checks++;
      if (bus.err_underflow !== e.val) begin errors++; $display("FAIL %s: got %b expected %b", e.name, bus.err_underflow, e.val); end
      idle();
   endtask

   initial begin
      rst = 1'b1;
      idle();
      @(negedge clk);
      test_reset();
      test_raw();
      test_saturation();
      test_same_cycle();
      test_store();
      test_flush();
      test_store_full_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/wb_scoreboard.md
# wb_scoreboard

Per-thread pending-write scoreboard that sits at the retirement end of the pipeline, opposite the hazard unit's issue-side instruction history. Issue marks a destination register as pending. Writeback clears it. Decode queries it for RAW hazards and for the store-ordering rule (no load/store while a store is in flight). Counters, not single bits, allow several in-flight writes to the same register.

## Interface
Parameters:
- THREADS, 4, number of hardware threads
- REGS, 32, architectural registers per thread
- CNTW, 2, width of each per-register pending counter (max 2^CNTW-1 in flight)
- STW, 3, width of the global in-flight store counter

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- iss_valid  in  1  instruction issued this cycle
- iss_thread  in  $clog2(THREADS)  issuing thread
- iss_wr  in  1  issued instruction writes iss_dst
- iss_dst  in  $clog2(REGS)  destination register
- iss_store  in  1  issued instruction is stb/stw
- iss_ready  out  1  issue may be accepted this cycle
- wb_valid  in  1  register write retired
- wb_thread  in  $clog2(THREADS)  retiring thread
- wb_dst  in  $clog2(REGS)  retired destination
- st_done  in  1  one store completed in memory
- flush_valid  in  1  squash all pending state of flush_thread
- flush_thread  in  $clog2(THREADS)  thread to flush
- q_thread  in  $clog2(THREADS)  query thread
- q_src1, q_src2  in  $clog2(REGS)  query sources
- q_mem  in  1  queried instruction is a load or store
- q_hazard  out  1  queried instruction must stall
- err_underflow  out  1  sticky: retire/st_done with counter at 0

## Operation
- State: cnt[THREADS][REGS] of CNTW bits; st_cnt of STW bits; err_underflow flop.
- Issue accepted when iss_valid && iss_ready.
  - If iss_wr is set: cnt[iss_thread][iss_dst] += 1.
  - If iss_store is set: st_cnt += 1.
- iss_ready = 0 when either is true:
  - iss_wr && cnt[iss_thread][iss_dst] == 2^CNTW-1
  - iss_store && st_cnt == 2^STW-1
  - Otherwise iss_ready = 1. It is combinational from registered state and does not depend on iss_valid.
- Retire: wb_valid decrements cnt[wb_thread][wb_dst]. If that counter is 0, leave it at 0 and set err_underflow.
- st_done decrements st_cnt. If st_cnt is 0, hold it and set err_underflow.
- Same-cycle accepted issue and retire on the same counter: net unchanged, no error, including when the counter is at 0.
- Same rule applies to store issue plus st_done on st_cnt.
- Flush: all cnt[flush_thread][*] go to 0 next cycle.
  - Flush wins over any same-cycle issue or retire for that thread; those are discarded and raise no error.
  - Other threads are unaffected.
  - st_cnt is not flushed, because issued stores still complete.
- q_hazard = (cnt[q_thread][q_src1] != 0) || (cnt[q_thread][q_src2] != 0) || (q_mem && st_cnt != 0). It is combinational from registered state only.
- err_underflow is sticky until rst.

## Timing
- Reset: all cnt = 0, st_cnt = 0, err_underflow = 0. Hence iss_ready = 1 and q_hazard = 0 out of reset.
- rst asserted mid-operation clears everything at that edge; issue/retire in that cycle are ignored.
- Issue at edge N: the counter is visible to q_hazard and iss_ready from cycle N+1.
- Retire at edge N: the hazard clears from cycle N+1. There is no same-cycle writeback bypass (conservative).
- No same-cycle issue bypass into the query: a query and an issue in cycle N see pre-issue state.
- Flush takes effect from cycle N+1.
- Counter saturation is never exceeded; counter wrap is impossible by construction.

## Test plan
1. Reset, then issue T0 wr r5. Next cycle query T0 src1=r5 -> q_hazard=1; the same query on T1 -> q_hazard=0. wb T0 r5 -> q_hazard=0 one cycle later.
2. Issue T2 wr r7 three times (CNTW=2) -> iss_ready=0 for wr r7 while iss_ready=1 for r8. One wb of r7 -> iss_ready returns to 1 next cycle; after three wbs total, q_hazard=0.
3. Same cycle: issue T1 wr r3 and wb T1 r3 with the counter at 1 -> counter stays 1, err_underflow=0. The same pair with the counter at 0 -> counter 0, no error.
4. Issue store (st_cnt=1). Query q_mem=1 with clean srcs -> q_hazard=1; q_mem=0 -> 0. st_done -> q_mem hazard clears next cycle. A second st_done -> err_underflow=1, sticky.
5. T0 has r1, r2 pending and T3 has r1 pending. flush T0 plus same-cycle issue T0 wr r4 -> next cycle all T0 queries give 0 (r4 not pending); T3 r1 still gives hazard.
6. Fill st_cnt to 7 -> iss_ready=0 for a store and 1 for a non-store. Assert rst mid-stream -> all outputs return to reset values next cycle.
